// File: rtl/conv_stage_stream.sv
// conv_stage_stream: buffers an HxWxC map from BRAM, then runs a K x K x C
// valid-mode convolution per filter, one MAC per cycle, streaming results.
module conv_stage_stream #(
  parameter int IMG_H    = 8,
  parameter int IMG_W    = 8,
  parameter int CHANNELS = 3,
  parameter int NUM_F    = 4,
  parameter int K        = 3,
  parameter int DATA_W   = 17,
  parameter int FILT_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int ACC_W    = 35,
  localparam int FW = (NUM_F > 1) ? $clog2(NUM_F) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      relu_en,
  input  logic [NUM_F*CHANNELS*K*K*FILT_W-1:0]      weights,
  output logic                                      busy,
  output logic                                      enable_read,
  output logic [ADDR_W-1:0]                         read_addr,
  input  logic [DATA_W-1:0]                         BRAM_input,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ACC_W-1:0]                          out_data,
  output logic [FW-1:0]                             out_filter,
  output logic [RW-1:0]                             out_row,
  output logic [CW-1:0]                             out_col,
  output logic                                      done
);

  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int N_IN  = IMG_H * IMG_W * CHANNELS;
  localparam int TAPS  = CHANNELS * K * K;
  localparam int BW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int LW    = $clog2(N_IN + 1);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int PW    = DATA_W + FILT_W;

  if (K > IMG_H || K > IMG_W) begin : g_bad_k
    $error("conv_stage_stream: kernel larger than image");
  end
  if ((longint'(1) << ADDR_W) < longint'(N_IN)) begin : g_bad_addr
    $error("conv_stage_stream: ADDR_W too small for feature map");
  end
  if (ACC_W < PW + $clog2(TAPS)) begin : g_bad_acc
    $error("conv_stage_stream: ACC_W too small");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LW-1:0]            ld_q, ld_d;
  logic [CHW-1:0]           ch_q, ch_d;
  logic [KW-1:0]            kr_q, kr_d;
  logic [KW-1:0]            kc_q, kc_d;
  logic [FW-1:0]            f_q, f_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            c_q, c_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     relu_q, relu_d;

  logic signed [DATA_W-1:0] buf_q [N_IN];

  logic                     ld_last;
  logic                     tap_first;
  logic                     tap_last;
  logic                     res_last;
  logic [BW-1:0]            bidx;
  int                       widx;
  logic signed [DATA_W-1:0] a_op;
  logic signed [FILT_W-1:0] w_op;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_x;

  assign ld_last   = (ld_q == LW'(N_IN));
  assign tap_first = (ch_q == '0) && (kr_q == '0) && (kc_q == '0);
  assign tap_last  = (ch_q == CHW'(CHANNELS - 1))
                  && (kr_q == KW'(K - 1))
                  && (kc_q == KW'(K - 1));
  assign res_last  = (f_q == FW'(NUM_F - 1))
                  && (r_q == RW'(OUT_H - 1))
                  && (c_q == CW'(OUT_W - 1));

  assign bidx = BW'((int'(ch_q) * IMG_H + int'(r_q) + int'(kr_q))
                * IMG_W + int'(c_q) + int'(kc_q));
  assign widx = ((int'(f_q) * CHANNELS + int'(ch_q)) * K
                + int'(kr_q)) * K + int'(kc_q);

  assign a_op   = buf_q[bidx];
  assign w_op   = weights[widx*FILT_W +: FILT_W];
  assign prod   = a_op * w_op;
  assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Word for address ld_q-1 arrives one cycle after its read.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && ld_q != '0) begin
      buf_q[BW'(ld_q - 1'b1)] <= BRAM_input;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (ld_last) state_d = S_MAC;
      S_MAC:  if (tap_last) state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready) state_d = res_last ? S_DONE : S_MAC;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_d   = ld_q;
    ch_d   = ch_q;
    kr_d   = kr_q;
    kc_d   = kc_q;
    f_d    = f_q;
    r_d    = r_q;
    c_d    = c_q;
    acc_d  = acc_q;
    relu_d = relu_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d = relu_en;
          ld_d   = '0;
          ch_d   = '0;
          kr_d   = '0;
          kc_d   = '0;
          f_d    = '0;
          r_d    = '0;
          c_d    = '0;
        end
      end
      S_LOAD: begin
        ld_d = ld_last ? '0 : ld_q + 1'b1;
      end
      S_MAC: begin
        acc_d = (tap_first ? '0 : acc_q) + prod_x;
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d = '0;
            ch_d = (ch_q == CHW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (c_q == CW'(OUT_W - 1)) begin
            c_d = '0;
            if (r_q == RW'(OUT_H - 1)) begin
              r_d = '0;
              f_d = (f_q == FW'(NUM_F - 1)) ? '0 : f_q + 1'b1;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q   <= '0;
      ch_q   <= '0;
      kr_q   <= '0;
      kc_q   <= '0;
      f_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      acc_q  <= '0;
      relu_q <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      ch_q   <= ch_d;
      kr_q   <= kr_d;
      kc_q   <= kc_d;
      f_q    <= f_d;
      r_q    <= r_d;
      c_q    <= c_d;
      acc_q  <= acc_d;
      relu_q <= relu_d;
    end
  end

  always_comb begin
    busy        = 1'b0;
    enable_read = 1'b0;
    read_addr   = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_filter  = '0;
    out_row     = '0;
    out_col     = '0;
    done        = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        busy = 1'b1;
        if (!ld_last) begin
          enable_read = 1'b1;
          read_addr   = ADDR_W'(ld_q);
        end
      end
      S_MAC: busy = 1'b1;
      S_EMIT: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_data   = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
        out_filter = f_q;
        out_row    = r_q;
        out_col    = c_q;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/conv_stage_stream.md
Name: conv_stage_stream

Overview:
- Parametrised successor to the stage-2 convolution block.
- Reads an H×W×C feature map from BRAM into a local buffer, then convolves it with NUM_F signed K×K×C filters (valid mode, stride 1).
- Runs one multiply-accumulate per cycle and streams each result out over a valid/ready handshake, instead of exposing one wide parallel output array.
- Adds start/done control and an optional ReLU mode.

Parameters:
- IMG_H, 8, input rows
- IMG_W, 8, input columns
- CHANNELS, 3, input channels
- NUM_F, 4, number of filters
- K, 3, kernel side
- DATA_W, 17, BRAM word width, signed
- FILT_W, 8, weight width, signed
- ADDR_W, 8, BRAM address width; must satisfy 2^ADDR_W ≥ IMG_H*IMG_W*CHANNELS
- ACC_W, 35, accumulator/output width, signed; must be ≥ DATA_W+FILT_W+clog2(CHANNELS*K*K)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; accepted only in IDLE
- relu_en  in  1  sampled with start; clamps negative results to 0
- weights  in  NUM_F*CHANNELS*K*K*FILT_W  flattened weights; element index ((f*CHANNELS+ch)*K+kr)*K+kc, element 0 at LSBs
- busy  out  1  high from the start-accept cycle until done
- enable_read  out  1  BRAM read enable
- read_addr  out  ADDR_W  BRAM address = (ch*IMG_H+row)*IMG_W+col
- BRAM_input  in  DATA_W  BRAM read data, valid 1 cycle after enable_read
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  convolution result
- out_filter  out  clog2(NUM_F)  filter index of the current result
- out_row  out  clog2(IMG_H)  output row
- out_col  out  clog2(IMG_W)  output column
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0; FSM goes to IDLE; counters and accumulator clear.
  - The buffer is not cleared.
  - Reset mid-run aborts the run with no done pulse.
- Derived sizes: OUT_H = IMG_H-K+1, OUT_W = IMG_W-K+1, N_IN = IMG_H*IMG_W*CHANNELS, TAPS = CHANNELS*K*K.
- IDLE:
  - start=1 → LOAD; busy=1 from the next cycle; relu_en is latched.
  - start is ignored in every other state, including the cycle done pulses.
- LOAD:
  - enable_read=1 with read_addr counting 0..N_IN-1 on consecutive cycles.
  - BRAM_input is captured one cycle later into buffer[addr].
  - After the last capture (N_IN+1 cycles in LOAD) → MAC; enable_read drops after addr N_IN-1.
- MAC:
  - One tap per cycle, ordered ch outer, kr, kc inner.
  - acc += sext(buffer[ch][r+kr][c+kc]) * sext(w[f][ch][kr][kc]).
  - acc clears at the first tap; TAPS cycles per result; → EMIT.
- EMIT:
  - out_valid=1; out_data = (relu && acc<0) ? 0 : acc.
  - out_filter/out_row/out_col show the current f, r, c.
  - All outputs hold stable while out_ready=0.
  - On out_valid && out_ready: advance c, then r, then f (f outer, row, col inner). out_valid drops the next cycle unless another result is ready; the next result appears after TAPS MAC cycles.
  - After the last result (f=NUM_F-1, r=OUT_H-1, c=OUT_W-1) is accepted → DONE.
- DONE: done=1 and busy=0 for one cycle → IDLE.
- Throughput and totals:
  - Minimum TAPS+1 cycles per result.
  - Total results NUM_F*OUT_H*OUT_W (144 at defaults).
- Arithmetic:
  - All products and sums are signed two's complement at ACC_W.
  - ACC_W is sized so no overflow occurs; no saturation is applied.
- weights must stay stable while busy; changes during a run give undefined results.
- Parameter checks: K>IMG_H or K>IMG_W, or ADDR_W too small, is an elaboration error.

Test Plan:
- Ones case, IMG_H=IMG_W=4, CHANNELS=1, NUM_F=1, K=3; BRAM all 1, weights all 1 → 4 results of 9, order (0,0),(0,1),(1,0),(1,1); done 1 cycle after the 4th handshake. The same BRAM/weight/ReLU setup with CHANNELS=2, NUM_F=2 also checks the address order and weight indexing.
- Defaults; BRAM word a = a, filter 0 has a single 1 at (ch=2,kr=1,kc=1), other filters zero → filter-0 result (r,c) = 128+(r+1)*8+(c+1); filters 1–3 give 0; 144 results total; read_addr 0..191 contiguous.
- ReLU and signs: BRAM all −5, weights all 1 (4×4, C=1, F=1):
  - relu_en=0 → out_data = −45 (sign-extended to ACC_W).
  - relu_en=1 → out_data = 0.
  - Extreme check: all data −65536 × all weights −128 → 9×8388608 with no overflow.
- Backpressure: hold out_ready=0 for 10 cycles on the 2nd result → out_valid, out_data and indices stable; no result lost or duplicated; total count unchanged.
- Control boundaries:
  - start pulsed during LOAD/MAC/EMIT → ignored, sequence unchanged.
  - start in the done cycle → ignored.
  - start the cycle after done → new run begins.
- Reset mid-run: assert reset during MAC of the 3rd result → all outputs 0 immediately, no done pulse; a subsequent start produces the full, correct result sequence.
